// File: rtl/rf_ctrl_pkg.sv
// Shared constants and write-request bundle for the regfile write-port arbiter.
package rf_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits for outstanding long-latency destinations plus decode hazard lookup.
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en_i,
    input  logic [AW-1:0]   set_idx_i,
    input  logic            clr_en_i,
    input  logic [AW-1:0]   clr_idx_i,
    input  logic [AW-1:0]   rs1_i,
    input  logic [AW-1:0]   rs2_i,
    input  logic [AW-1:0]   rd_i,
    output logic [NREG-1:0] busy_o,
    output logic            stall_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    function automatic logic hit(input logic [NREG-1:0] b,
                                 input logic [AW-1:0] idx);
        return (idx != '0) && b[idx];
    endfunction

    // A new issue to the index being retired this cycle keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i)
            busy_d[clr_idx_i] = 1'b0;
        if (set_en_i && set_idx_i != '0)
            busy_d[set_idx_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_o  = busy_q;
    assign stall_o = hit(busy_q, rs1_i)
                   | hit(busy_q, rs2_i)
                   | hit(busy_q, rd_i);

endmodule

// File: rtl/rf_wport_arbiter.sv
// Regfile write-port arbiter: pipeline writeback first, then a one-entry
// hold buffer, then a direct long-latency result.
module rf_wport_arbiter
    import rf_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_we,
    input  logic [AW-1:0]   pipe_rd,
    input  logic [XLEN-1:0] pipe_wd,
    input  logic            ll_issue,
    input  logic [AW-1:0]   ll_issue_rd,
    input  logic            ll_valid,
    input  logic [AW-1:0]   ll_rd,
    input  logic [XLEN-1:0] ll_wd,
    output logic            ll_ready,
    input  logic [AW-1:0]   dec_rs1,
    input  logic [AW-1:0]   dec_rs2,
    input  logic [AW-1:0]   dec_rd,
    output logic            dec_stall,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wd,
    output logic [NREG-1:0] sb_busy
);

    rf_wr_t          pipe_req;
    rf_wr_t          ll_req;
    rf_wr_t          port;
    rf_wr_t          hold_q;
    rf_wr_t          hold_d;
    logic            ll_hs;
    logic            ll_commit;
    logic [NREG-1:0] busy;

    assign ll_ready = rst_n && !hold_q.we;
    assign ll_hs    = ll_valid && ll_ready;

    always_comb begin
        pipe_req = '{we: pipe_we && pipe_rd != '0, addr: pipe_rd, data: pipe_wd};
        ll_req   = '{we: ll_hs && ll_rd != '0, addr: ll_rd, data: ll_wd};
    end

    always_comb begin
        port      = '0;
        ll_commit = 1'b0;
        if (!rst_n) begin
            port = '0;
        end else if (pipe_req.we) begin
            port = pipe_req;
        end else if (hold_q.we) begin
            port      = hold_q;
            ll_commit = 1'b1;
        end else if (ll_req.we) begin
            port      = ll_req;
            ll_commit = 1'b1;
        end
    end

    // Capture only happens when hold is empty, so drain and capture never collide.
    always_comb begin
        hold_d = hold_q;
        if (hold_q.we && !pipe_req.we)
            hold_d = '0;
        if (ll_req.we && pipe_req.we)
            hold_d = ll_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_q <= '0;
        else
            hold_q <= hold_d;
    end

    rf_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en_i  (ll_issue),
        .set_idx_i (ll_issue_rd),
        .clr_en_i  (ll_commit),
        .clr_idx_i (port.addr),
        .rs1_i     (dec_rs1),
        .rs2_i     (dec_rs2),
        .rd_i      (dec_rd),
        .busy_o    (busy),
        .stall_o   (dec_stall)
    );

    assign rf_we    = port.we;
    assign rf_waddr = port.addr;
    assign rf_wd    = port.data;
    assign sb_busy  = busy;

    a_issue_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (ll_issue && ll_issue_rd != '0
         && !(ll_commit && port.addr == ll_issue_rd))
        |-> !busy[ll_issue_rd]);

    a_pipe_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (pipe_we && pipe_rd != '0) |-> !busy[pipe_rd]);

    a_ll_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (ll_valid && ll_rd != '0) |-> busy[ll_rd]);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench: directed vector table, reset sequences, and a
// randomized run checked against a queue-based reference model.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        ll_issue;
    logic [4:0]  ll_issue_rd;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_wd;
    logic        ll_ready;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wd;
    logic [31:0] sb_busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_wd     (pipe_wd),
        .ll_issue    (ll_issue),
        .ll_issue_rd (ll_issue_rd),
        .ll_valid    (ll_valid),
        .ll_rd       (ll_rd),
        .ll_wd       (ll_wd),
        .ll_ready    (ll_ready),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_stall   (dec_stall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wd       (rf_wd),
        .sb_busy     (sb_busy)
    );

    typedef struct {
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pwd;
        logic        iss;
        logic [4:0]  ird;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] lwd;
        logic [4:0]  r1, r2, rd;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        erdy;
        logic        estl;
        logic [31:0] esb;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } hold_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic pwe, logic [4:0] prd, logic [31:0] pwd,
        logic iss, logic [4:0] ird,
        logic lv, logic [4:0] lrd, logic [31:0] lwd,
        logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
        logic ewe, logic [4:0] ea, logic [31:0] ed,
        logic erdy, logic estl, logic [31:0] esb);
        vec_t v;
        v.pwe = pwe; v.prd = prd; v.pwd = pwd;
        v.iss = iss; v.ird = ird;
        v.lv = lv; v.lrd = lrd; v.lwd = lwd;
        v.r1 = r1; v.r2 = r2; v.rd = rd;
        v.ewe = ewe; v.ea = ea; v.ed = ed;
        v.erdy = erdy; v.estl = estl; v.esb = esb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_all(input string tag, input logic ewe,
                             input logic [4:0] ea, input logic [31:0] ed,
                             input logic erdy, input logic estl,
                             input logic [31:0] esb);
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(ewe));
        chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(ea));
        chk({tag, ".rf_wd"}, rf_wd, ed);
        chk({tag, ".ll_ready"}, 32'(ll_ready), 32'(erdy));
        chk({tag, ".dec_stall"}, 32'(dec_stall), 32'(estl));
        chk({tag, ".sb_busy"}, sb_busy, esb);
    endtask

    task automatic idle_inputs();
        pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
        ll_issue = 0; ll_issue_rd = 0;
        ll_valid = 0; ll_rd = 0; ll_wd = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    endtask

    task automatic apply(input vec_t v);
        pipe_we = v.pwe; pipe_rd = v.prd; pipe_wd = v.pwd;
        ll_issue = v.iss; ll_issue_rd = v.ird;
        ll_valid = v.lv; ll_rd = v.lrd; ll_wd = v.lwd;
        dec_rs1 = v.r1; dec_rs2 = v.r2; dec_rd = v.rd;
    endtask

    bit [31:0] mbusy;
    hold_t     mhold[$];
    int        outst[$];

    initial begin
        // reset with active requests: everything must read zero
        rst_n = 0;
        idle_inputs();
        pipe_we = 1; pipe_rd = 3; pipe_wd = 32'h1234;
        ll_valid = 1; ll_rd = 7; ll_wd = 32'h5678;
        dec_rs1 = 1; dec_rs2 = 2; dec_rd = 3;
        #12;
        check_all("rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        idle_inputs();
        #2;
        check_all("post_rst", 0, 0, 0, 1, 0, 0);

        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,            0,0,0, 0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0, 1,5, 0,0,0,            5,0,0, 0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,            5,0,0, 0,0,0,            1,1,'h20));
        tbl.push_back(mk(0,0,0, 0,0, 1,5,'hDEADBEEF,   5,0,0, 1,5,'hDEADBEEF,   1,1,'h20));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,            5,0,0, 0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0, 1,7, 0,0,0,            0,0,0, 0,0,0,            1,0,0));
        tbl.push_back(mk(1,3,'h11, 0,0, 1,7,'h22,      0,0,0, 1,3,'h11,         1,0,'h80));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,            0,7,0, 1,7,'h22,         0,1,'h80));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,            0,7,0, 0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0, 1,8, 0,0,0,            0,0,0, 0,0,0,            1,0,0));
        tbl.push_back(mk(1,1,'hA1, 0,0, 1,8,'h88,      0,0,0, 1,1,'hA1,         1,0,'h100));
        tbl.push_back(mk(1,2,'hA2, 0,0, 0,0,0,         0,0,0, 1,2,'hA2,         0,0,'h100));
        tbl.push_back(mk(1,3,'hA3, 0,0, 0,0,0,         0,0,0, 1,3,'hA3,         0,0,'h100));
        tbl.push_back(mk(1,4,'hA4, 0,0, 0,0,0,         0,0,0, 1,4,'hA4,         0,0,'h100));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,            0,0,0, 1,8,'h88,         0,0,'h100));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,            0,0,0, 0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0, 1,9, 0,0,0,            0,0,0, 0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0, 1,9, 1,9,'h99,         0,0,0, 1,9,'h99,         1,0,'h200));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,            0,0,9, 0,0,0,            1,1,'h200));
        tbl.push_back(mk(0,0,0, 0,0, 1,9,'h9A,         0,0,9, 1,9,'h9A,         1,1,'h200));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,            0,0,9, 0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0, 1,4, 0,0,0,            0,0,0, 0,0,0,            1,0,0));
        tbl.push_back(mk(1,0,'h55, 0,0, 1,4,'h44,      0,0,0, 1,4,'h44,         1,0,'h10));
        tbl.push_back(mk(0,0,0, 0,0, 1,0,'h77,         0,0,0, 0,0,0,            1,0,0));
        tbl.push_back(mk(1,6,'h66, 0,0, 1,0,'h78,      0,0,0, 1,6,'h66,         1,0,0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,            0,0,0, 0,0,0,            1,0,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            #2;
            check_all($sformatf("vec%0d", i), tbl[i].ewe, tbl[i].ea,
                      tbl[i].ed, tbl[i].erdy, tbl[i].estl, tbl[i].esb);
        end

        // reset while the hold buffer is full discards hold and busy bits
        @(negedge clk);
        idle_inputs();
        ll_issue = 1; ll_issue_rd = 10;
        @(negedge clk);
        idle_inputs();
        pipe_we = 1; pipe_rd = 1; pipe_wd = 32'hB1;
        ll_valid = 1; ll_rd = 10; ll_wd = 32'hAAAA;
        @(negedge clk);
        idle_inputs();
        dec_rs1 = 10;
        #2;
        check_all("mid_full", 1, 10, 32'hAAAA, 0, 1, 32'h400);
        rst_n = 0;
        pipe_we = 1; pipe_rd = 2; pipe_wd = 32'hC2;
        #1;
        check_all("mid_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        idle_inputs();
        dec_rs1 = 10;
        #2;
        check_all("mid_rel", 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #2;
        check_all("mid_idle", 0, 0, 0, 1, 0, 0);

        // randomized run against the queue model
        mbusy = 0;
        mhold.delete();
        outst.delete();
        for (int c = 0; c < 2000; c++) begin
            logic        pact, rdy, hs, ewe;
            logic [4:0]  ea, r;
            logic [31:0] ed;
            @(negedge clk);
            idle_inputs();
            pipe_we = ($urandom % 3) != 0;
            pipe_rd = 5'($urandom_range(0, 31));
            if (mbusy[pipe_rd]) pipe_rd = 0;
            pipe_wd = $urandom;
            if (outst.size() > 0 && ($urandom % 2) == 1) begin
                ll_valid = 1;
                ll_rd = 5'(outst[0]);
            end
            ll_wd = $urandom;
            if (outst.size() < 3 && ($urandom % 3) == 0) begin
                r = 5'($urandom_range(0, 31));
                if (!(r != 0 && mbusy[r])) begin
                    ll_issue = 1;
                    ll_issue_rd = r;
                end
            end
            dec_rs1 = 5'($urandom_range(0, 31));
            dec_rs2 = 5'($urandom_range(0, 31));
            dec_rd  = 5'($urandom_range(0, 31));

            pact = pipe_we && pipe_rd != 0;
            rdy  = mhold.size() == 0;
            hs   = ll_valid && rdy;
            ewe = 0; ea = 0; ed = 0;
            if (pact) begin
                ewe = 1; ea = pipe_rd; ed = pipe_wd;
            end else if (!rdy) begin
                ewe = 1; ea = mhold[0].rd; ed = mhold[0].wd;
            end else if (hs && ll_rd != 0) begin
                ewe = 1; ea = ll_rd; ed = ll_wd;
            end
            #2;
            check_all($sformatf("rnd%0d", c), ewe, ea, ed, rdy,
                      (dec_rs1 != 0 && mbusy[dec_rs1])
                      || (dec_rs2 != 0 && mbusy[dec_rs2])
                      || (dec_rd != 0 && mbusy[dec_rd]),
                      mbusy);

            if (!pact && !rdy) begin
                mbusy[mhold[0].rd] = 0;
                void'(mhold.pop_front());
            end else if (!pact && hs && ll_rd != 0) begin
                mbusy[ll_rd] = 0;
            end
            if (hs) begin
                void'(outst.pop_front());
                if (pact && ll_rd != 0) mhold.push_back('{ll_rd, ll_wd});
            end
            if (ll_issue) begin
                if (ll_issue_rd != 0) mbusy[ll_issue_rd] = 1;
                outst.push_back(int'(ll_issue_rd));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
